alu_seq: RTL and testbench

//   Parametrised, handshaked successor to the single-cycle combinational ALU.

---
 rtl/alu_seq.sv | 183 ++++++++++++++++++
 tb/tb_alu_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith ops, iterative shift-add multiplier and
// optional restoring divider (enabled by defining ALU_SEQ_DIV_EN); result held until consumed.
module alu_seq #(
   parameter int WIDTH   = 32,
   parameter int CTRL_W  = 6,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] ALU_Control,
   input  logic [WIDTH-1:0]  operand_A,
   input  logic [WIDTH-1:0]  operand_B,
   input  logic              branch_op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  ALU_result,
   output logic              branch,
   output logic              illegal
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(6'b000000);
   localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(6'b001000);
   localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(6'b000010);
   localparam logic [CTRL_W-1:0] OP_SLTU = CTRL_W'(6'b000011);
   localparam logic [CTRL_W-1:0] OP_XOR  = CTRL_W'(6'b000100);
   localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(6'b000110);
   localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(6'b000111);
   localparam logic [CTRL_W-1:0] OP_SLL  = CTRL_W'(6'b000001);
   localparam logic [CTRL_W-1:0] OP_SRL  = CTRL_W'(6'b000101);
   localparam logic [CTRL_W-1:0] OP_SRA  = CTRL_W'(6'b001101);
   localparam logic [CTRL_W-1:0] OP_MUL  = CTRL_W'(6'b011000);
`ifdef ALU_SEQ_DIV_EN
   localparam logic [CTRL_W-1:0] OP_DIVU = CTRL_W'(6'b011100);
   localparam logic [CTRL_W-1:0] OP_REMU = CTRL_W'(6'b011110);
`endif

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
   typedef enum logic [1:0] {M_MUL = 2'd0, M_DIVU = 2'd1, M_REMU = 2'd2} mode_t;

   state_t             state_r, state_s;
   mode_t              mode_r, mode_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [WIDTH-1:0]   acc_r, opa_r, opb_r;
   logic [WIDTH-1:0]   result_r;
   logic               branch_r, illegal_r, branch_op_r;

   logic               accept_s, multi_s, illegal_s, last_step_s, div_ok_s;
   logic [WIDTH-1:0]   res_s, acc_n_s, opa_n_s, opb_n_s, final_s, mul_acc_s;
   logic [WIDTH:0]     rem_shift_s, diff_s;
   logic [SHAMT_W-1:0] shamt_s;

   assign in_ready    = (state_r == IDLE) | ((state_r == DONE) & out_ready);
   assign accept_s    = in_valid & in_ready;
   assign last_step_s = (cnt_r == CNT_W'(1));
   assign shamt_s     = operand_B[SHAMT_W-1:0];
   assign out_valid   = (state_r == DONE);
   assign ALU_result  = result_r;
   assign branch      = branch_r;
   assign illegal     = illegal_r;

   // Decode the request: single-cycle result, or which iterative engine to start.
   always_comb begin
      res_s     = {WIDTH{1'b0}};
      illegal_s = 1'b0;
      multi_s   = 1'b0;
      mode_s    = M_MUL;
      case (ALU_Control)
         OP_ADD:  res_s = operand_A + operand_B;
         OP_SUB:  res_s = operand_A - operand_B;
         OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(operand_A) < $signed(operand_B))};
         OP_SLTU: res_s = {{(WIDTH-1){1'b0}}, (operand_A < operand_B)};
         OP_XOR:  res_s = operand_A ^ operand_B;
         OP_OR:   res_s = operand_A | operand_B;
         OP_AND:  res_s = operand_A & operand_B;
         OP_SLL:  res_s = operand_A << shamt_s;
         OP_SRL:  res_s = operand_A >> shamt_s;
         OP_SRA:  res_s = $unsigned($signed(operand_A) >>> shamt_s);
         OP_MUL:  begin multi_s = 1'b1; mode_s = M_MUL; end
`ifdef ALU_SEQ_DIV_EN
         OP_DIVU: begin multi_s = 1'b1; mode_s = M_DIVU; end
         OP_REMU: begin multi_s = 1'b1; mode_s = M_REMU; end
`endif
         default: illegal_s = 1'b1;
      endcase
   end

   // One iteration step; acc_r is the product (MUL) or partial remainder (DIV), opa_r the quotient.
   always_comb begin
      mul_acc_s   = acc_r + (opb_r[0] ? opa_r : {WIDTH{1'b0}});
      rem_shift_s = {acc_r, opa_r[WIDTH-1]};
      diff_s      = rem_shift_s - {1'b0, opb_r};
      div_ok_s    = ~diff_s[WIDTH];
      acc_n_s     = acc_r;
      opa_n_s     = opa_r;
      opb_n_s     = opb_r;
      final_s     = {WIDTH{1'b0}};
      case (mode_r)
         M_MUL: begin
            acc_n_s = mul_acc_s;
            opa_n_s = opa_r << 1;
            opb_n_s = opb_r >> 1;
            final_s = mul_acc_s;
         end
         M_DIVU, M_REMU: begin
            acc_n_s = div_ok_s ? diff_s[WIDTH-1:0] : rem_shift_s[WIDTH-1:0];
            opa_n_s = {opa_r[WIDTH-2:0], div_ok_s};
            final_s = (mode_r == M_DIVU) ? opa_n_s : acc_n_s;
         end
         default: final_s = {WIDTH{1'b0}};
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_s = multi_s ? BUSY : DONE;
            else          state_s = IDLE;
         end
         BUSY: begin
            if (last_step_s) state_s = DONE;
            else             state_s = BUSY;
         end
         DONE: begin
            if (accept_s)       state_s = multi_s ? BUSY : DONE;
            else if (out_ready) state_s = IDLE;
            else                state_s = DONE;
         end
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_r <= IDLE;
      else       state_r <= state_s;
   end

   // Operand capture, iteration datapath and held result registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mode_r      <= M_MUL;
         cnt_r       <= {CNT_W{1'b0}};
         acc_r       <= {WIDTH{1'b0}};
         opa_r       <= {WIDTH{1'b0}};
         opb_r       <= {WIDTH{1'b0}};
         result_r    <= {WIDTH{1'b0}};
         branch_r    <= 1'b0;
         illegal_r   <= 1'b0;
         branch_op_r <= 1'b0;
      end else if (accept_s) begin
         mode_r      <= mode_s;
         cnt_r       <= CNT_W'(WIDTH);
         acc_r       <= {WIDTH{1'b0}};
         opa_r       <= operand_A;
         opb_r       <= operand_B;
         branch_op_r <= branch_op;
         result_r    <= res_s;
         illegal_r   <= illegal_s;
         branch_r    <= branch_op & ~illegal_s & ~multi_s & (res_s == {WIDTH{1'b0}});
      end else if (state_r == BUSY) begin
         cnt_r <= cnt_r - CNT_W'(1);
         acc_r <= acc_n_s;
         opa_r <= opa_n_s;
         opb_r <= opb_n_s;
         if (last_step_s) begin
            result_r  <= final_s;
            illegal_r <= 1'b0;
            branch_r  <= branch_op_r & (final_s == {WIDTH{1'b0}});
         end else begin
            result_r  <= result_r;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32); define ALU_SEQ_DIV_EN to cover the divider.
module tb_alu_seq;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, branch_op, out_valid, out_ready, branch, illegal;
   logic [5:0]  ALU_Control;
   logic [31:0] operand_A, operand_B, ALU_result;

   int checks = 0;
   int errors = 0;

   localparam logic [5:0] ADD = 6'b000000, SUB = 6'b001000, SLT = 6'b000010, SLTU = 6'b000011;
   localparam logic [5:0] XOR = 6'b000100, OR = 6'b000110, AND = 6'b000111, SLL = 6'b000001;
   localparam logic [5:0] SRL = 6'b000101, SRA = 6'b001101, MUL = 6'b011000;
   localparam logic [5:0] DIVU = 6'b011100, REMU = 6'b011110, BAD = 6'b111111;

   alu_seq dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .ALU_Control(ALU_Control), .operand_A(operand_A), .operand_B(operand_B),
      .branch_op(branch_op), .out_valid(out_valid), .out_ready(out_ready),
      .ALU_result(ALU_result), .branch(branch), .illegal(illegal)
   );

   always #5 clock = ~clock;

   // Issue one request, scramble inputs after accept, wait for out_valid (bounded).
   // lat counts clock edges from the accept edge (inclusive) until out_valid is seen.
   task automatic do_op(input logic [5:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        input logic br, output int lat, output int busy_rdy);
      int guard;
      ALU_Control = ctrl; operand_A = a; operand_B = b; branch_op = br; in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clock); #1; guard++;
      end
      @(posedge clock); #1;
      in_valid = 1'b0; ALU_Control = SUB; operand_A = 32'hDEADBEEF; operand_B = 32'h0BADF00D;
      branch_op = 1'b0;
      lat = 1; busy_rdy = 0;
      while (!out_valid && lat < 100) begin
         if (in_ready) busy_rdy++;
         @(posedge clock); #1; lat++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; branch_op = 1'b0;
      ALU_Control = ADD; operand_A = 32'h0; operand_B = 32'h0;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || ALU_result !== 32'h0 ||
          branch !== 1'b0 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: ov=%b ir=%b res=%h br=%b il=%b, want 0 1 0 0 0",
                  out_valid, in_ready, ALU_result, branch, illegal);
      end
      reset = 1'b0;
   endtask

   task automatic test_add_sub();
      int lat, br;
      logic [5:0]  ops  [3] = '{ADD, SUB, SUB};
      logic [31:0] as   [3] = '{32'd4, 32'd4, 32'd5};
      logic [31:0] bs   [3] = '{32'd5, 32'hFFFFFFFF, 32'd5};
      logic        brs  [3] = '{1'b0, 1'b0, 1'b1};
      logic [31:0] exp  [3] = '{32'd9, 32'd5, 32'd0};
      logic        expb [3] = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         do_op(ops[i], as[i], bs[i], brs[i], lat, br);
         checks++;
         if (ALU_result !== exp[i] || branch !== expb[i] || illegal !== 1'b0 || lat !== 1) begin
            errors++;
            $display("FAIL add_sub[%0d]: res=%h br=%b il=%b lat=%0d, want %h %b 0 1",
                     i, ALU_result, branch, illegal, lat, exp[i], expb[i]);
         end
      end
   endtask

   task automatic test_logic_shift();
      int lat, br;
      logic [5:0]  ops [9] = '{SLT, SLT, SLTU, XOR, AND, SRA, OR, SLL, SRL};
      logic [31:0] as  [9] = '{32'd4, 32'hFFFFFFF0, 32'd4, 32'h35, 32'h35, 32'h80000000,
                               32'h35, 32'h1, 32'h80000000};
      logic [31:0] bs  [9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h26, 32'h26, 32'd4,
                               32'h26, 32'd31, 32'd35};
      logic [31:0] exp [9] = '{32'd0, 32'd1, 32'd1, 32'h13, 32'h24, 32'hF8000000,
                               32'h37, 32'h80000000, 32'h10000000};
      for (int i = 0; i < 9; i++) begin
         do_op(ops[i], as[i], bs[i], 1'b0, lat, br);
         checks++;
         if (ALU_result !== exp[i] || illegal !== 1'b0 || lat !== 1) begin
            errors++;
            $display("FAIL logic_shift[%0d]: res=%h il=%b lat=%0d, want %h 0 1",
                     i, ALU_result, illegal, lat, exp[i]);
         end
      end
   endtask

   task automatic test_illegal();
      int lat, br;
      do_op(BAD, 32'h12, 32'h34, 1'b1, lat, br);
      checks++;
      if (ALU_result !== 32'h0 || illegal !== 1'b1 || branch !== 1'b0 || lat !== 1) begin
         errors++;
         $display("FAIL illegal_code: res=%h il=%b br=%b lat=%0d, want 0 1 0 1",
                  ALU_result, illegal, branch, lat);
      end
   endtask

   task automatic test_mul();
      int lat, br;
      do_op(MUL, 32'd7, 32'hFFFFFFFF, 1'b0, lat, br);
      checks++;
      if (ALU_result !== 32'hFFFFFFF9 || lat !== 33 || br !== 0 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL mul_neg: res=%h lat=%0d busy_ready=%0d, want fffffff9 33 0",
                  ALU_result, lat, br);
      end
      do_op(MUL, 32'h12345678, 32'h10, 1'b1, lat, br);
      checks++;
      if (ALU_result !== 32'h23456780 || branch !== 1'b0 || lat !== 33) begin
         errors++;
         $display("FAIL mul_pos: res=%h br=%b lat=%0d, want 23456780 0 33", ALU_result, branch, lat);
      end
   endtask

   task automatic test_back_to_back();
      int lat, br;
      do_op(ADD, 32'd10, 32'd20, 1'b0, lat, br);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         checks++;
         if (out_valid !== 1'b1 || ALU_result !== 32'd30 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold[%0d]: ov=%b res=%h ir=%b, want 1 0000001e 0",
                     i, out_valid, ALU_result, in_ready);
         end
      end
      out_ready = 1'b1; in_valid = 1'b1; ALU_Control = SUB; operand_A = 32'd9; operand_B = 32'd3;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release_ready: in_ready=%b, want 1", in_ready);
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || ALU_result !== 32'd6) begin
         errors++;
         $display("FAIL same_cycle_accept: ov=%b res=%h, want 1 00000006", out_valid, ALU_result);
      end
   endtask

   task automatic test_reset_mid_mul();
      int lat, br;
      in_valid = 1'b1; ALU_Control = MUL; operand_A = 32'd3; operand_B = 32'd5;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || ALU_result !== 32'h0 || in_ready !== 1'b1 ||
          branch !== 1'b0 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_mul: ov=%b res=%h ir=%b br=%b il=%b, want 0 0 1 0 0",
                  out_valid, ALU_result, in_ready, branch, illegal);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (30) @(posedge clock);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_abort: ov=%b ir=%b, want 0 1", out_valid, in_ready);
      end
      do_op(ADD, 32'd1, 32'd1, 1'b0, lat, br);
      checks++;
      if (ALU_result !== 32'd2 || lat !== 1) begin
         errors++;
         $display("FAIL add_after_reset: res=%h lat=%0d, want 00000002 1", ALU_result, lat);
      end
   endtask

   task automatic test_div();
      int lat, br;
`ifdef ALU_SEQ_DIV_EN
      logic [5:0]  ops [4] = '{DIVU, REMU, DIVU, REMU};
      logic [31:0] as  [4] = '{32'd100, 32'd100, 32'd9, 32'd9};
      logic [31:0] bs  [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
      logic [31:0] exp [4] = '{32'd14, 32'd2, 32'hFFFFFFFF, 32'd9};
      for (int i = 0; i < 4; i++) begin
         do_op(ops[i], as[i], bs[i], 1'b0, lat, br);
         checks++;
         if (ALU_result !== exp[i] || illegal !== 1'b0 || lat !== 33) begin
            errors++;
            $display("FAIL div[%0d]: res=%h il=%b lat=%0d, want %h 0 33",
                     i, ALU_result, illegal, lat, exp[i]);
         end
      end
`else
      do_op(DIVU, 32'd100, 32'd7, 1'b0, lat, br);
      checks++;
      if (ALU_result !== 32'h0 || illegal !== 1'b1 || lat !== 1) begin
         errors++;
         $display("FAIL divu_disabled: res=%h il=%b lat=%0d, want 0 1 1", ALU_result, illegal, lat);
      end
      do_op(REMU, 32'd100, 32'd7, 1'b0, lat, br);
      checks++;
      if (ALU_result !== 32'h0 || illegal !== 1'b1 || lat !== 1) begin
         errors++;
         $display("FAIL remu_disabled: res=%h il=%b lat=%0d, want 0 1 1", ALU_result, illegal, lat);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_logic_shift();
      test_illegal();
      test_mul();
      test_back_to_back();
      test_reset_mid_mul();
      test_div();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
